// File: rtl/mem_bist_pkg.sv
// Shared definitions for the register-file BIST controller: FSM states and
// the march data pattern.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W0,
        ST_R0,
        ST_W1,
        ST_R1,
        ST_DONE
    } bist_state_t;

    localparam logic [7:0] PAT_OFFSET_DEFAULT = 8'h05;

    // Callers truncate the result to their data width (mod 2**DW).
    function automatic logic [31:0] bist_pat(input logic [31:0] i, input logic [31:0] off);
        return (i << 4) + off;
    endfunction

endpackage

// File: rtl/mem_bist_chk.sv
// Read-data comparator: counts mismatches and captures the first failing
// location and phase.
module mem_bist_chk
    import mem_bist_pkg::*;
#(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] expected,
    input  logic [DW-1:0] actual,
    input  logic [AW-1:0] idx,
    input  logic          phase,
    output logic [AW+1:0] err_count,
    output logic [AW-1:0] first_fail_addr,
    output logic          first_fail_phase
);

    logic mismatch;

    always_comb begin
        mismatch = en && (expected != actual);
    end

    // err_count is wide enough for 2*DEPTH mismatches, so no saturation is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count        <= '0;
            first_fail_addr  <= '0;
            first_fail_phase <= 1'b0;
        end else if (clr) begin
            err_count        <= '0;
            first_fail_addr  <= '0;
            first_fail_phase <= 1'b0;
        end else if (mismatch) begin
            err_count <= err_count + (AW+2)'(1);
            if (err_count == '0) begin
                first_fail_addr  <= idx;
                first_fail_phase <= phase;
            end
        end
    end

endmodule

// File: rtl/mem_bist_ctrl.sv
// March BIST initiator for small sync-write/async-read register files:
// W0 pattern, R0 verify, W1 inverted pattern, R1 verify, then report.
module mem_bist_ctrl
    import mem_bist_pkg::*;
#(
    parameter int            AW         = 3,
    parameter int            DW         = 8,
    parameter logic [DW-1:0] PAT_OFFSET = DW'(PAT_OFFSET_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW+1:0] err_count,
    output logic [AW-1:0] first_fail_addr,
    output logic          first_fail_phase
);

    localparam logic [AW-1:0] IDX_LAST = '1;

    bist_state_t   state, state_nx;
    logic [AW-1:0] idx, idx_nx;
    logic [DW-1:0] pat_idx;
    logic [DW-1:0] exp_data;
    logic          pass_q;
    logic          launch;
    logic          kill;
    logic          in_read;

    always_comb begin
        pat_idx  = DW'(bist_pat(32'(idx), 32'(PAT_OFFSET)));
        exp_data = (state == ST_R1) ? ~pat_idx : pat_idx;
        in_read  = (state == ST_R0) || (state == ST_R1);
        launch   = (state == ST_IDLE) && start && !abort;
        kill     = (state != ST_IDLE) && abort;
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            ST_IDLE: begin
                if (launch) begin
                    state_nx = ST_W0;
                    idx_nx   = '0;
                end
            end
            ST_W0, ST_R0, ST_W1, ST_R1: begin
                idx_nx = idx + AW'(1);
                if (idx == IDX_LAST) begin
                    case (state)
                        ST_W0:   state_nx = ST_R0;
                        ST_R0:   state_nx = ST_W1;
                        ST_W1:   state_nx = ST_R1;
                        default: state_nx = ST_DONE;
                    endcase
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
        if (kill) begin
            state_nx = ST_IDLE;
            idx_nx   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            idx    <= '0;
            pass_q <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            if (launch || kill) begin
                pass_q <= 1'b0;
            end else if (state == ST_DONE) begin
                pass_q <= (err_count == '0);
            end
        end
    end

    // Memory port and status are decoded from registered state only.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        busy     = (state != ST_IDLE);
        done     = (state == ST_DONE);
        pass     = (state == ST_DONE) ? (err_count == '0) : pass_q;
        case (state)
            ST_W0: begin
                mem_we   = 1'b1;
                mem_addr = idx;
                mem_din  = pat_idx;
            end
            ST_W1: begin
                mem_we   = 1'b1;
                mem_addr = idx;
                mem_din  = ~pat_idx;
            end
            ST_R0, ST_R1: mem_addr = idx;
            default: ;
        endcase
    end

    mem_bist_chk #(
        .AW(AW),
        .DW(DW)
    ) u_chk (
        .clk             (clk),
        .rst_n           (rst_n),
        .clr             (launch),
        .en              (in_read),
        .expected        (exp_data),
        .actual          (mem_dout),
        .idx             (idx),
        .phase           (state == ST_R1),
        .err_count       (err_count),
        .first_fail_addr (first_fail_addr),
        .first_fail_phase(first_fail_phase)
    );

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Scoreboard bench for mem_bist_ctrl paired with an 8x8 register-file model
// that can inject read faults.
module tb_mem_bist_ctrl;

    typedef struct {
        bit         is_done;
        int         cyc;
        logic [2:0] addr;
        logic [7:0] din;
        logic       pass;
        logic [4:0] err;
        logic [2:0] ffa;
        logic       ffp;
    } item_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       mem_we;
    logic [2:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic [2:0] first_fail_addr;
    logic       first_fail_phase;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int cur = 0;
    int mode = 0;
    item_t sb[$];
    item_t mon_it;

    logic [7:0] mem [8];
    logic [7:0] pat_tab [8] = '{8'h05, 8'h15, 8'h25, 8'h35, 8'h45, 8'h55, 8'h65, 8'h75};
    logic [7:0] inv_tab [8] = '{8'hFA, 8'hEA, 8'hDA, 8'hCA, 8'hBA, 8'hAA, 8'h9A, 8'h8A};

    mem_bist_ctrl #(.AW(3), .DW(8), .PAT_OFFSET(8'h05)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_din         (mem_din),
        .mem_dout        (mem_dout),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_fail_addr (first_fail_addr),
        .first_fail_phase(first_fail_phase)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;

    always @* begin
        mem_dout = mem[mem_addr];
        if (mode == 1) mem_dout = {mem[mem_addr][7:1], 1'b0};
        if (mode == 2 && mem_addr == 3'd5 && mem[mem_addr] == 8'hAA) mem_dout = 8'hAB;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_writes(input int n0, input int n1);
        item_t it;
        it = '{default: '0};
        for (int i = 0; i < n0; i++) begin
            it.addr = 3'(i); it.din = pat_tab[i]; it.cyc = 1 + i;
            sb.push_back(it);
        end
        for (int i = 0; i < n1; i++) begin
            it.addr = 3'(i); it.din = inv_tab[i]; it.cyc = 17 + i;
            sb.push_back(it);
        end
    endtask

    task automatic push_done(input logic p, input logic [4:0] e, input logic [2:0] a, input logic ph);
        item_t it;
        it = '{default: '0};
        it.is_done = 1'b1; it.cyc = 33;
        it.pass = p; it.err = e; it.ffa = a; it.ffp = ph;
        sb.push_back(it);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1 start = 1'b0;
        cur = 1;
    endtask

    task automatic goto(input int n);
        while (cur < n) begin
            @(posedge clk);
            #1 cur++;
        end
    endtask

    // Monitor: every write or done the DUT presents consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && (mem_we || done)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: we=%0b done=%0b at cycle %0d, expected none",
                         mem_we, done, cyc - t0);
            end else begin
                mon_it = sb.pop_front();
                chk("out_kind", int'(done), int'(mon_it.is_done));
                chk("out_cycle", cyc - t0, mon_it.cyc);
                if (mon_it.is_done) begin
                    chk("done_pass", pass, mon_it.pass);
                    chk("done_err_count", err_count, mon_it.err);
                    chk("done_first_fail_addr", first_fail_addr, mon_it.ffa);
                    chk("done_first_fail_phase", first_fail_phase, mon_it.ffp);
                end else begin
                    chk("wr_addr", mem_addr, mon_it.addr);
                    chk("wr_din", mem_din, mon_it.din);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #23;
        chk("reset_outputs",
            {mem_we, mem_addr, mem_din, busy, done, pass, err_count, first_fail_addr, first_fail_phase}, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: healthy memory
        mode = 0;
        push_writes(8, 8); push_done(1'b1, 5'd0, 3'd0, 1'b0);
        do_start();
        chk("s1_busy_c1", busy, 1);
        goto(34);
        chk("s1_pass_held", pass, 1);
        chk("s1_busy_idle", busy, 0);
        chk("s1_drained", sb.size(), 0);

        // 2: dout[0] stuck at 0
        mode = 1;
        push_writes(8, 8); push_done(1'b0, 5'd8, 3'd0, 1'b0);
        do_start();
        chk("s2_pass_cleared", pass, 0);
        goto(34);
        chk("s2_pass_held", pass, 0);
        chk("s2_err_held", err_count, 8);
        chk("s2_drained", sb.size(), 0);

        // 3: read at addr 5 corrupted only while it holds 0xAA
        mode = 2;
        push_writes(8, 8); push_done(1'b0, 5'd1, 3'd5, 1'b1);
        do_start();
        chk("s3_err_cleared", err_count, 0);
        goto(34);
        chk("s3_drained", sb.size(), 0);

        // 4: start while busy is ignored, then a fresh run
        mode = 0;
        push_writes(8, 8); push_done(1'b1, 5'd0, 3'd0, 1'b0);
        do_start();
        goto(10); start = 1'b1;
        goto(11); start = 1'b0;
        goto(34);
        chk("s4_drained", sb.size(), 0);
        push_writes(8, 8); push_done(1'b1, 5'd0, 3'd0, 1'b0);
        do_start();
        goto(34);
        chk("s4b_drained", sb.size(), 0);

        // 5: reset in W1, then a clean full run
        push_writes(8, 3);
        do_start();
        goto(20); rst_n = 1'b0;
        #1 chk("s5_reset_outputs",
               {mem_we, mem_addr, mem_din, busy, done, pass, err_count, first_fail_addr, first_fail_phase}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("s5_idle_after_release", busy, 0);
        chk("s5_drained", sb.size(), 0);
        push_writes(8, 8); push_done(1'b1, 5'd0, 3'd0, 1'b0);
        do_start();
        goto(34);
        chk("s5b_drained", sb.size(), 0);

        // 6: abort in R0
        push_writes(8, 0);
        do_start();
        chk("s6_pass_cleared", pass, 0);
        goto(12); abort = 1'b1;
        goto(13); abort = 1'b0;
        chk("s6_busy_after_abort", busy, 0);
        chk("s6_pass_after_abort", pass, 0);
        chk("s6_err_kept", err_count, 0);
        goto(45);
        chk("s6_drained", sb.size(), 0);

        // start and abort together in IDLE: abort wins
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", busy, 0);
        repeat (3) @(negedge clk);
        chk("final_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
